// File: rtl/regfile_fwd_sb_pkg.sv
// Shared definitions for the bypassed register file: stall reason codes.
package regfile_fwd_sb_pkg;

    typedef enum logic [1:0] {
        RF_STALL_NONE = 2'd0,
        RF_STALL_LOAD = 2'd1,
        RF_STALL_MC   = 2'd2,
        RF_STALL_BLK  = 2'd3
    } stall_why_t;

endpackage

// File: rtl/regfile_fwd_sb_read_port.sv
// One combinational read port: EX/ME/link/WB bypass plus load-use and multi-cycle hazard detection.
module rf_read_port #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LINK_REG = 31,
    parameter int LOAD_ME  = 0
) (
    input  logic [AW-1:0] addr,
    input  logic          used,
    input  logic [DW-1:0] arr_data,
    input  logic          ex_we,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_data,
    input  logic          ex_load,
    input  logic          me_we,
    input  logic [AW-1:0] me_addr,
    input  logic [DW-1:0] me_data,
    input  logic          me_load,
    input  logic          lk_we,
    input  logic [DW-1:0] lk_data,
    input  logic          w_we,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          busy,
    input  logic          mc_done,
    input  logic [AW-1:0] mc_dest_q,
    output logic [DW-1:0] data,
    output logic          load_haz,
    output logic          mc_haz
);
    import regfile_fwd_sb_pkg::*;

    localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
    localparam bit            LME    = (LOAD_ME != 0);

    logic nz;
    assign nz = (addr != '0);

    // Youngest producer wins; the link port outranks WB because it also wins the write.
    always_comb begin
        data = arr_data;
        if (!nz)
            data = '0;
        else if (ex_we && ex_addr == addr)
            data = ex_data;
        else if (me_we && me_addr == addr)
            data = me_data;
        else if (lk_we && addr == LINK_A)
            data = lk_data;
        else if (w_we && w_addr == addr)
            data = w_data;
    end

    assign load_haz = used && nz &&
                      ((ex_we && ex_load && ex_addr == addr) ||
                       (LME && me_we && me_load && me_addr == addr));
    assign mc_haz   = busy && !mc_done && used && nz && (addr == mc_dest_q);

endmodule

// File: rtl/regfile_fwd_sb.sv
// GPR file with bypassed read ports, link write port, one-entry multi-cycle scoreboard and stall counter.
module regfile_fwd_sb
    import regfile_fwd_sb_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int LINK_REG = 31,
    parameter int LOAD_ME  = 0,
    parameter int CNTW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_we,
    input  logic [AW-1:0]     w_addr,
    input  logic [DW-1:0]     w_data,
    input  logic              lk_we,
    input  logic [DW-1:0]     lk_data,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_used,
    output logic [NRD*DW-1:0] rd_data,
    input  logic              ex_we,
    input  logic [AW-1:0]     ex_addr,
    input  logic [DW-1:0]     ex_data,
    input  logic              ex_load,
    input  logic              me_we,
    input  logic [AW-1:0]     me_addr,
    input  logic [DW-1:0]     me_data,
    input  logic              me_load,
    input  logic              mc_issue,
    input  logic [AW-1:0]     mc_dest,
    input  logic              mc_done,
    output logic              stall,
    output logic [1:0]        stall_why,
    output logic [CNTW-1:0]   stall_cnt,
    output logic              mc_err
);
    localparam int            DEPTH  = 2 ** AW;
    localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

    logic [DW-1:0]  regs [DEPTH];
    logic           busy;
    logic [AW-1:0]  dest_q;
    logic [NRD-1:0] load_haz;
    logic [NRD-1:0] mc_haz;
    logic           blocked;
    stall_why_t     why_c;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        rf_read_port #(
            .DW(DW), .AW(AW), .LINK_REG(LINK_REG), .LOAD_ME(LOAD_ME)
        ) u_port (
            .addr     (rd_addr[i*AW +: AW]),
            .used     (rd_used[i]),
            .arr_data (regs[rd_addr[i*AW +: AW]]),
            .ex_we    (ex_we),
            .ex_addr  (ex_addr),
            .ex_data  (ex_data),
            .ex_load  (ex_load),
            .me_we    (me_we),
            .me_addr  (me_addr),
            .me_data  (me_data),
            .me_load  (me_load),
            .lk_we    (lk_we),
            .lk_data  (lk_data),
            .w_we     (w_we),
            .w_addr   (w_addr),
            .w_data   (w_data),
            .busy     (busy),
            .mc_done  (mc_done),
            .mc_dest_q(dest_q),
            .data     (rd_data[i*DW +: DW]),
            .load_haz (load_haz[i]),
            .mc_haz   (mc_haz[i])
        );
    end

    assign blocked = mc_issue && busy && !mc_done;
    assign stall   = (|load_haz) || (|mc_haz);

    always_comb begin
        why_c = RF_STALL_NONE;
        if (|load_haz)
            why_c = RF_STALL_LOAD;
        else if (|mc_haz)
            why_c = RF_STALL_MC;
        else if (blocked)
            why_c = RF_STALL_BLK;
    end
    assign stall_why = why_c;

    // Link write is issued after the main write so it takes the register on a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++)
                regs[r] <= '0;
        end else begin
            if (w_we && w_addr != '0)
                regs[w_addr] <= w_data;
            if (lk_we && LINK_A != '0)
                regs[LINK_A] <= lk_data;
        end
    end

    // A blocked issue leaves the tracked op untouched; only the error flag records it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            dest_q    <= '0;
            mc_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (mc_issue && (!busy || mc_done)) begin
                busy   <= 1'b1;
                dest_q <= mc_dest;
            end else if (mc_done) begin
                busy <= 1'b0;
            end
            if (blocked)
                mc_err <= 1'b1;
            if (stall && stall_cnt != {CNTW{1'b1}})
                stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

endmodule
